ex_muldiv_ctrl: RTL and testbench
=================================

Name: ex_muldiv_ctrl

Overview:
- Sequences an iterative multiply/divide unit beside the EX-stage ALU and owns the architectural HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX using operands already forwarded by the EX forwarding logic.
- Raises a stall to the hazard logic while an operation is in flight or while a MFHI/MFLO in EX would read stale HI/LO.
- Aborts cleanly on interrupt flush.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count of the shift/add-subtract engine.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- intterupt  input  1  pipeline flush; aborts the in-flight operation.
- startEX  input  1  valid mul/div/move instruction in EX this cycle.
- opEX  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved, treated as no-op.
- in1EX  input  WIDTH  forwarded rs value.
- in2EX  input  WIDTH  forwarded rt value.
- mfreqEX  input  1  MFHI/MFLO currently in EX.
- busy  output  1  engine running.
- stallEX  output  1  freeze IF/ID/EX, bubble MEM.
- done  output  1  one-cycle pulse when HI/LO are updated by mul/div.
- divzero  output  1  one-cycle pulse with done when a DIV/DIVU had a zero divisor.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, reset=0): state IDLE; hi=0, lo=0, busy=0, stallEX=0, done=0, divzero=0; all internal accumulators and counters 0.
- States:
  - IDLE
  - RUN: counter counts WIDTH-1 down to 0, one bit per cycle.
  - FIX: sign correction and HI/LO write.
- IDLE, startEX=1 with MULT..DIVU: latch operands. Signed ops latch magnitudes plus result sign bits. Go to RUN with counter=WIDTH-1.
- IDLE, startEX=1 with MTHI/MTLO: hi or lo takes in1EX at that edge. No stall, no done.
- RUN: multiply is shift-add over the 2*WIDTH product. Divide is restoring, one quotient bit per cycle. Counter=0 moves to FIX.
- FIX:
  - Multiply: product negated if signs differ; hi={upper}, lo={lower}.
  - Divide: quotient negated if rs sign xor rt sign; remainder takes the sign of rs.
  - done=1, return to IDLE.
- Latency: start accepted at edge N, busy=1 from N; done and HI/LO valid after edge N+WIDTH+1 (WIDTH+1 busy cycles).
- busy=1 in RUN and FIX.
- stallEX = busy | (mfreqEX & busy) | (startEX & busy). A new mul/div or MFHI/MFLO issued while busy is held in EX until IDLE. stallEX is combinational from state and inputs.
- startEX while busy is ignored by the engine. The stalled instruction re-presents startEX once IDLE is reached.
- Divide by zero: completes with normal latency; lo=all ones, hi=in1EX (unsigned magnitude semantics before sign fix are bypassed); divzero=1 with done.
- Signed overflow -2^(WIDTH-1) / -1: lo=0x80000000, hi=0, no flag.
- intterupt=1 in any state: next edge goes to IDLE, busy=0, hi/lo unchanged, no done. intterupt has priority over startEX in the same cycle.
- Reserved opEX: no state change.

Optional Feature:
- MULDIV_EARLY_OUT_EN defined: MULT/MULTU leave RUN for FIX as soon as the remaining multiplier bits are all zero. Minimum 1 RUN cycle, so a multiply by 0 or 1 completes in 2 busy cycles. Divide timing is unchanged.
- Undefined: every mul/div takes exactly WIDTH+1 busy cycles.

Test Plan:
- Reset held low mid-RUN of MULT 7*9 -> all outputs 0 immediately; after release, IDLE with hi=lo=0.
- MULT 0xFFFFFFFF(-1) * 0x00000003 -> done after 33 busy cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFD. MULTU of the same operands -> hi=0x00000002, lo=0xFFFFFFFD.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=14, hi=2.
- DIVU 5 / 0 -> lo=0xFFFFFFFF, hi=5, divzero and done pulse together.
- MULT started, mfreqEX=1 on the next cycle -> stallEX held high until the done cycle. MTLO 0x1234 issued in IDLE -> lo=0x1234 next edge, stallEX=0.
- intterupt asserted at busy cycle 10 of DIV -> busy drops next edge; hi/lo keep their prior values; no done. With MULDIV_EARLY_OUT_EN, MULT 5*1 -> done after 2 busy cycles, lo=5.

Source files
------------

// File: rtl/ex_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_ctrl
// Description : Iterative multiply/divide sequencer beside the EX-stage ALU.
//               Owns the architectural HI/LO registers, runs a one-bit-per-
//               cycle shift/add multiplier and restoring divider, and stalls
//               the front of the pipe while an operation is in flight.
//               Optional macro MULDIV_EARLY_OUT_EN lets MULT/MULTU finish as
//               soon as the remaining multiplier bits are all zero.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             intterupt,
    input  logic             startEX,
    input  logic [2:0]       opEX,
    input  logic [WIDTH-1:0] in1EX,
    input  logic [WIDTH-1:0] in2EX,
    input  logic             mfreqEX,
    output logic             busy,
    output logic             stallEX,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] c_OP_MULT  = 3'd0;
    localparam logic [2:0] c_OP_MULTU = 3'd1;
    localparam logic [2:0] c_OP_DIV   = 3'd2;
    localparam logic [2:0] c_OP_DIVU  = 3'd3;
    localparam logic [2:0] c_OP_MTHI  = 3'd4;
    localparam logic [2:0] c_OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_isDiv;
    logic                   r_negQ;      // product / quotient must be negated
    logic                   r_negR;      // remainder must be negated
    logic                   r_divZero;
    logic [WIDTH-1:0]       r_rsRaw;     // original rs, returned in HI on divide by zero
    logic [2*WIDTH-1:0]     r_mcand;     // multiplicand (shifts left) or divisor in low half
    logic [WIDTH-1:0]       r_mplr;      // multiplier (shifts right) or dividend/quotient
    logic [2*WIDTH-1:0]     r_acc;       // product accumulator or partial remainder

    logic                   w_isMulDiv;
    logic                   w_isSigned;
    logic                   w_isDivOp;
    logic [WIDTH-1:0]       w_magA;
    logic [WIDTH-1:0]       w_magB;
    logic [WIDTH:0]         w_partial;
    logic [WIDTH:0]         w_trial;
    logic [2*WIDTH-1:0]     w_prodSum;
    logic [2*WIDTH-1:0]     w_prodFix;
    logic [WIDTH-1:0]       w_quotFix;
    logic [WIDTH-1:0]       w_remFix;
    logic                   w_earlyOut;

    // Operand decode, magnitude extraction and per-iteration datapath
    always_comb begin
        w_isMulDiv = (opEX == c_OP_MULT) || (opEX == c_OP_MULTU) ||
                     (opEX == c_OP_DIV)  || (opEX == c_OP_DIVU);
        w_isSigned = (opEX == c_OP_MULT) || (opEX == c_OP_DIV);
        w_isDivOp  = (opEX == c_OP_DIV)  || (opEX == c_OP_DIVU);
        w_magA     = (w_isSigned && in1EX[WIDTH-1]) ? -in1EX : in1EX;
        w_magB     = (w_isSigned && in2EX[WIDTH-1]) ? -in2EX : in2EX;
        // Restoring divide: shift next dividend bit into the remainder, try subtract
        w_partial  = {r_acc[WIDTH-1:0], r_mplr[WIDTH-1]};
        w_trial    = w_partial - {1'b0, r_mcand[WIDTH-1:0]};
        // Shift-add multiply: add shifted multiplicand when current multiplier bit is set
        w_prodSum  = r_acc + (r_mplr[0] ? r_mcand : {(2*WIDTH){1'b0}});
        w_prodFix  = r_negQ ? -r_acc : r_acc;
        w_quotFix  = r_negQ ? -r_mplr : r_mplr;
        w_remFix   = r_negR ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    end

`ifdef MULDIV_EARLY_OUT_EN
    // Multiply may stop once no set bits remain above the one being consumed
    assign w_earlyOut = ~r_isDiv & ~(|r_mplr[WIDTH-1:1]);
`else
    assign w_earlyOut = 1'b0;
`endif

    // Hold the pipe while busy; new mul/div or MFHI/MFLO in EX waits for IDLE
    assign stallEX = busy | (mfreqEX & busy) | (startEX & busy);

    // Sequencer FSM with registered outputs and HI/LO ownership
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_isDiv   <= 1'b0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
            r_divZero <= 1'b0;
            r_rsRaw   <= '0;
            r_mcand   <= '0;
            r_mplr    <= '0;
            r_acc     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            divzero   <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            done    <= 1'b0;
            divzero <= 1'b0;
            if (intterupt) begin
                // Flush wins over everything, including a start in the same cycle
                r_state <= S_IDLE;
                busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (startEX) begin
                            if (w_isMulDiv) begin
                                r_isDiv   <= w_isDivOp;
                                r_negQ    <= w_isSigned & (in1EX[WIDTH-1] ^ in2EX[WIDTH-1]);
                                r_negR    <= w_isSigned & in1EX[WIDTH-1];
                                r_divZero <= w_isDivOp & (in2EX == '0);
                                r_rsRaw   <= in1EX;
                                r_mcand   <= {{WIDTH{1'b0}}, (w_isDivOp ? w_magB : w_magA)};
                                r_mplr    <= w_isDivOp ? w_magA : w_magB;
                                r_acc     <= '0;
                                r_cnt     <= c_CNT_W'(WIDTH - 1);
                                r_state   <= S_RUN;
                                busy      <= 1'b1;
                            end else if (opEX == c_OP_MTHI) begin
                                hi <= in1EX;
                            end else if (opEX == c_OP_MTLO) begin
                                lo <= in1EX;
                            end
                        end
                    end
                    S_RUN: begin
                        if (r_isDiv) begin
                            r_mplr <= {r_mplr[WIDTH-2:0], ~w_trial[WIDTH]};
                            r_acc  <= {{WIDTH{1'b0}},
                                       (w_trial[WIDTH] ? w_partial[WIDTH-1:0] : w_trial[WIDTH-1:0])};
                        end else begin
                            r_acc   <= w_prodSum;
                            r_mcand <= r_mcand << 1;
                            r_mplr  <= r_mplr >> 1;
                        end
                        if ((r_cnt == '0) || w_earlyOut) begin
                            r_state <= S_FIX;
                        end else begin
                            r_cnt <= r_cnt - c_CNT_W'(1);
                        end
                    end
                    S_FIX: begin
                        if (!r_isDiv) begin
                            hi <= w_prodFix[2*WIDTH-1:WIDTH];
                            lo <= w_prodFix[WIDTH-1:0];
                        end else if (r_divZero) begin
                            hi <= r_rsRaw;
                            lo <= {WIDTH{1'b1}};
                        end else begin
                            hi <= w_remFix;
                            lo <= w_quotFix;
                        end
                        done    <= 1'b1;
                        divzero <= r_divZero;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv_ctrl
// Description : Self-checking bench for ex_muldiv_ctrl. Expected HI/LO,
//               divide-by-zero flag and busy length are queued when an
//               operation is issued and compared when done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_ctrl;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             intterupt;
    logic             startEX;
    logic [2:0]       opEX;
    logic [WIDTH-1:0] in1EX;
    logic [WIDTH-1:0] in2EX;
    logic             mfreqEX;
    logic             busy;
    logic             stallEX;
    logic             done;
    logic             divzero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    ex_muldiv_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .intterupt (intterupt),
        .startEX   (startEX),
        .opEX      (opEX),
        .in1EX     (in1EX),
        .in2EX     (in2EX),
        .mfreqEX   (mfreqEX),
        .busy      (busy),
        .stallEX   (stallEX),
        .done      (done),
        .divzero   (divzero),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t lastExp;
    int   nChecks = 0;
    int   nFails  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference results computed with native SystemVerilog arithmetic
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      p;
        logic [63:0] u;
        int          q;
        int          r;
        e.hi  = '0;
        e.lo  = '0;
        e.dz  = 1'b0;
        e.lat = WIDTH + 1;
        case (op)
            3'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {e.hi, e.lo} = p;
            end
            3'd1: begin
                u = {32'b0, a} * {32'b0, b};
                {e.hi, e.lo} = u;
            end
            3'd2: begin
                if (b == 0) begin
                    e.lo = 32'hFFFF_FFFF; e.hi = a; e.dz = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000; e.hi = 32'h0;
                end else begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                    e.lo = q; e.hi = r;
                end
            end
            3'd3: begin
                if (b == 0) begin
                    e.lo = 32'hFFFF_FFFF; e.hi = a; e.dz = 1'b1;
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
            default: ;
        endcase
`ifdef MULDIV_EARLY_OUT_EN
        if (op == 3'd0 || op == 3'd1) begin
            logic [31:0] mag;
            int          runs;
            mag  = (op == 3'd0 && b[31]) ? -b : b;
            runs = 1;
            for (int i = 1; i < 32; i++) if ((mag >> i) != 0) runs = i + 1;
            e.lat = runs + 1;
        end
`endif
        return e;
    endfunction

    // Issue one mul/div; when stress is set, MFHI/MFLO waits in EX and a
    // stray MTLO is presented mid-operation (both must be held off)
    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit stress);
        exp_t g;
        int   cyc;
        int   guard;
        @(negedge clk);
        opEX = op; in1EX = a; in2EX = b; startEX = 1'b1;
        sb.push_back(model(op, a, b));
        @(negedge clk);
        startEX = 1'b0;
        if (stress) mfreqEX = 1'b1;
        cyc = 0;
        for (guard = 0; guard < 200 && !done; guard++) begin
            if (busy) begin
                cyc++;
                if (stress) check("stall_busy", stallEX, 1);
            end
            if (stress) begin
                startEX = (cyc == 5);
                if (cyc == 5) begin opEX = 3'd5; in1EX = 32'hDEAD_BEEF; end
            end
            @(negedge clk);
        end
        startEX = 1'b0;
        g = sb.pop_front();
        check("done_seen", done, 1);
        if (done) begin
            check("hi", hi, g.hi);
            check("lo", lo, g.lo);
            check("divzero", divzero, g.dz);
            check("busy_cycles", cyc, g.lat);
            check("busy_at_done", busy, 0);
            if (stress) check("stall_at_done", stallEX, 0);
            lastExp = g;
            mfreqEX = 1'b0;
            @(negedge clk);
            check("done_pulse", done, 0);
            check("divzero_pulse", divzero, 0);
        end
        mfreqEX = 1'b0;
    endtask

    // MTHI/MTLO: no stall, no done, register updated at the next edge
    task automatic moveTo(input logic [2:0] op, input logic [31:0] v);
        @(negedge clk);
        opEX = op; in1EX = v; startEX = 1'b1;
        #1 check("mt_stall", stallEX, 0);
        @(negedge clk);
        startEX = 1'b0;
        if (op == 3'd4) lastExp.hi = v; else lastExp.lo = v;
        check("mt_hi", hi, lastExp.hi);
        check("mt_lo", lo, lastExp.lo);
        check("mt_busy", busy, 0);
        check("mt_done", done, 0);
    endtask

    initial begin
        bit sawDone;
        int cyc;
        reset = 1'b0; intterupt = 1'b0; startEX = 1'b0; opEX = '0;
        in1EX = '0; in2EX = '0; mfreqEX = 1'b0;
        lastExp.hi = '0; lastExp.lo = '0; lastExp.dz = 1'b0; lastExp.lat = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_stall", stallEX, 0);
        check("rst_done", done, 0);
        check("rst_divzero", divzero, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        reset = 1'b1;

        moveTo(3'd4, 32'hAAAA_0000);
        moveTo(3'd5, 32'h0000_5555);

        // Asynchronous reset in the middle of MULT 7*9
        @(negedge clk);
        opEX = 3'd0; in1EX = 32'd7; in2EX = 32'd9; startEX = 1'b1;
        @(negedge clk);
        startEX = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy_before", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_stall", stallEX, 0);
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);
        check("post_rst_hi", hi, 0);
        check("post_rst_lo", lo, 0);
        lastExp.hi = '0; lastExp.lo = '0;

        moveTo(3'd5, 32'h0000_1234);

        // Directed arithmetic cases
        runOp(3'd0, 32'hFFFF_FFFF, 32'd3, 1'b0);
        runOp(3'd1, 32'hFFFF_FFFF, 32'd3, 1'b0);
        runOp(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        runOp(3'd3, 32'd100, 32'd7, 1'b0);
        runOp(3'd3, 32'd5, 32'd0, 1'b0);
        runOp(3'd2, 32'hFFFF_FFF0, 32'd0, 1'b0);
        runOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        runOp(3'd0, 32'd5, 32'd1, 1'b0);
        runOp(3'd1, 32'h1234_5678, 32'd0, 1'b0);
        runOp(3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        runOp(3'd0, 32'd123, 32'hFFFF_FF00, 1'b1);

        // Random operations
        for (int i = 0; i < 8; i++) begin
            runOp(3'($urandom_range(0, 3)), $urandom, $urandom, 1'b0);
        end

        // Flush at busy cycle 10 of a DIV
        runOp(3'd3, 32'd100, 32'd7, 1'b0);
        @(negedge clk);
        opEX = 3'd2; in1EX = 32'hFFFF_FFF9; in2EX = 32'd2; startEX = 1'b1;
        @(negedge clk);
        startEX = 1'b0;
        cyc = 0;
        for (int g = 0; g < 50 && cyc < 10; g++) begin
            if (busy) cyc++;
            if (cyc < 10) @(negedge clk);
        end
        check("int_reached_cycle10", cyc, 10);
        intterupt = 1'b1;
        @(negedge clk);
        intterupt = 1'b0;
        check("int_busy", busy, 0);
        check("int_stall", stallEX, 0);
        sawDone = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done) sawDone = 1'b1;
            @(negedge clk);
        end
        check("int_no_done", sawDone, 0);
        check("int_hi_kept", hi, lastExp.hi);
        check("int_lo_kept", lo, lastExp.lo);

        // Flush beats a start presented in the same cycle
        intterupt = 1'b1; startEX = 1'b1; opEX = 3'd4; in1EX = 32'hCAFE_F00D;
        @(negedge clk);
        intterupt = 1'b0; startEX = 1'b0;
        check("int_prio_hi", hi, lastExp.hi);
        intterupt = 1'b1; startEX = 1'b1; opEX = 3'd0; in1EX = 32'd3; in2EX = 32'd4;
        @(negedge clk);
        intterupt = 1'b0; startEX = 1'b0;
        check("int_prio_busy", busy, 0);

        // Reserved opcode is a no-op
        startEX = 1'b1; opEX = 3'd6; in1EX = 32'h5A5A_5A5A;
        @(negedge clk);
        startEX = 1'b0;
        check("rsvd_busy", busy, 0);
        check("rsvd_hi", hi, lastExp.hi);
        check("rsvd_lo", lo, lastExp.lo);

        // Engine still usable after the flushes
        runOp(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
